riscv_core_dpath_vec_wb_assembler: RTL and testbench

Writeback-side producer for the vector register file: collects a vector instruction's 32-bit element results one beat at a time and merges them with the destination's prior contents under `vl` and the element mask. It then issues a single-cycle 256-bit write on the regfile write port (`wen_p`, `waddr_p`, `wvec_p`). It sits between the vector execute lanes and the vector regfile in the W stage.

---
 rtl/riscv_vec_pkg.sv | 22 ++
 rtl/riscv_core_dpath_vec_elem_merge.sv | 22 ++
 rtl/riscv_core_dpath_vec_wb_assembler.sv | 132 +++++++++++++
 tb/tb_riscv_core_dpath_vec_wb_assembler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_vec_pkg.sv
// Shared vector datapath constants, W-stage writeback FSM encoding and vl helpers.
package riscv_vec_pkg;

    localparam int unsigned VLEN   = 256;
    localparam int unsigned ELEN   = 32;
    localparam int unsigned VLMAX  = VLEN / ELEN;
    // One extra bit so vl can express VLMAX itself (and the unclamped 9..15 range).
    localparam int unsigned VL_W   = $clog2(VLMAX) + 1;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2
    } wb_state_e;

    // Saturate a requested vector length at VLMAX.
    function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
        return (vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : vl;
    endfunction

endpackage

// File: rtl/riscv_core_dpath_vec_elem_merge.sv
// Combinational lane writer: replaces lane idx of the assembly buffer when enabled.
module riscv_core_dpath_vec_elem_merge
    import riscv_vec_pkg::*;
#(
    parameter int unsigned LANES = VLMAX,
    parameter int unsigned EW    = ELEN
) (
    input  logic [LANES*EW-1:0]        buf_in,
    input  logic [$clog2(LANES)-1:0]   idx,
    input  logic [EW-1:0]              elem_data,
    input  logic                       en,
    output logic [LANES*EW-1:0]        buf_out
);

    localparam int unsigned IW = $clog2(LANES);

    // Each lane either takes the new element or passes its current contents through.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign buf_out[i*EW +: EW] = (en && (idx == IW'(i))) ? elem_data : buf_in[i*EW +: EW];
    end

endmodule

// File: rtl/riscv_core_dpath_vec_wb_assembler.sv
// W-stage vector writeback assembler: gathers per-element results, merges them
// with the old destination under vl/mask, then issues one 256-bit regfile write.
module riscv_core_dpath_vec_wb_assembler #(
    parameter int unsigned VLMAX = riscv_vec_pkg::VLMAX,
    parameter int unsigned ELEN  = riscv_vec_pkg::ELEN
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start_val,
    output logic                                   start_rdy,
    input  logic [riscv_vec_pkg::REG_AW-1:0]       start_waddr,
    input  logic [riscv_vec_pkg::VL_W-1:0]         start_vl,
    input  logic [VLMAX-1:0]                       start_mask,
    input  logic [VLMAX*ELEN-1:0]                  start_old,
    input  logic                                   elem_val,
    output logic                                   elem_rdy,
    input  logic [ELEN-1:0]                        elem_data,
    input  logic                                   kill,
    output logic                                   wen_p,
    output logic [riscv_vec_pkg::REG_AW-1:0]       waddr_p,
    output logic [VLMAX*ELEN-1:0]                  wvec_p,
    output logic                                   done,
    output logic                                   busy
);

    import riscv_vec_pkg::VL_W;
    import riscv_vec_pkg::REG_AW;
    import riscv_vec_pkg::wb_state_e;
    import riscv_vec_pkg::ST_IDLE;
    import riscv_vec_pkg::ST_COLLECT;
    import riscv_vec_pkg::ST_WRITE;
    import riscv_vec_pkg::clamp_vl;

    localparam int unsigned VW = VLMAX * ELEN;
    localparam int unsigned IW = $clog2(VLMAX);

    wb_state_e         state_q;
    logic [VL_W-1:0]   vl_q;
    logic [VL_W-1:0]   idx_q;
    logic [VLMAX-1:0]  mask_q;
    logic [REG_AW-1:0] waddr_q;
    logic              wr_ok_q;
    logic [VW-1:0]     buf_q;
    logic [VW-1:0]     buf_nxt_c;
    logic [VL_W-1:0]   vl_clamp_c;
    logic              beat_c;
    logic              lane_en_c;
    logic              last_beat_c;

    // Handshake and status decode straight from the state register.
    assign start_rdy   = (state_q == ST_IDLE);
    assign elem_rdy    = (state_q == ST_COLLECT) && !kill;
    assign busy        = (state_q != ST_IDLE);
    assign vl_clamp_c  = clamp_vl(start_vl);
    assign beat_c      = elem_val && elem_rdy;
    assign lane_en_c   = beat_c && mask_q[idx_q[IW-1:0]];
    assign last_beat_c = beat_c && (idx_q == (vl_q - VL_W'(1)));

    riscv_core_dpath_vec_elem_merge #(
        .LANES (VLMAX),
        .EW    (ELEN)
    ) u_merge (
        .buf_in    (buf_q),
        .idx       (idx_q[IW-1:0]),
        .elem_data (elem_data),
        .en        (lane_en_c),
        .buf_out   (buf_nxt_c)
    );

    // FSM, element counter, op latches and registered write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vl_q    <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            waddr_q <= '0;
            wr_ok_q <= 1'b0;
            buf_q   <= '0;
            wen_p   <= 1'b0;
            waddr_p <= '0;
            wvec_p  <= '0;
            done    <= 1'b0;
        end else begin
            wen_p <= 1'b0;
            done  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_val) begin
                        vl_q    <= vl_clamp_c;
                        mask_q  <= start_mask;
                        waddr_q <= start_waddr;
                        buf_q   <= start_old;
                        idx_q   <= '0;
                        // x0 is hardwired; a write to it is dropped but the op still completes.
                        wr_ok_q <= (start_waddr != '0);
                        if (vl_clamp_c == '0) begin
                            state_q <= ST_WRITE;
                            waddr_p <= start_waddr;
                            wvec_p  <= start_old;
                            done    <= 1'b1;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                    end else if (beat_c) begin
                        buf_q <= buf_nxt_c;
                        idx_q <= idx_q + VL_W'(1);
                        if (last_beat_c) begin
                            state_q <= ST_WRITE;
                            wen_p   <= wr_ok_q;
                            waddr_p <= waddr_q;
                            wvec_p  <= buf_nxt_c;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_dpath_vec_wb_assembler.sv
// Self-checking bench for the vector writeback assembler.
module tb_riscv_core_dpath_vec_wb_assembler;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_val;
    logic         start_rdy;
    logic [4:0]   start_waddr;
    logic [3:0]   start_vl;
    logic [7:0]   start_mask;
    logic [255:0] start_old;
    logic         elem_val;
    logic         elem_rdy;
    logic [31:0]  elem_data;
    logic         kill;
    logic         wen_p;
    logic [4:0]   waddr_p;
    logic [255:0] wvec_p;
    logic         done;
    logic         busy;

    always #5 clk = ~clk;

    riscv_core_dpath_vec_wb_assembler dut (
        .clk         (clk),
        .reset       (reset),
        .start_val   (start_val),
        .start_rdy   (start_rdy),
        .start_waddr (start_waddr),
        .start_vl    (start_vl),
        .start_mask  (start_mask),
        .start_old   (start_old),
        .elem_val    (elem_val),
        .elem_rdy    (elem_rdy),
        .elem_data   (elem_data),
        .kill        (kill),
        .wen_p       (wen_p),
        .waddr_p     (waddr_p),
        .wvec_p      (wvec_p),
        .done        (done),
        .busy        (busy)
    );

    typedef struct {
        logic [4:0]       waddr;
        logic [3:0]       vl;
        logic [7:0]       mask;
        logic [255:0]     old;
        logic [7:0][31:0] beats;
        int               gap;
        int               kill_after;
        bit               extra_beat;
        logic             exp_wen;
        logic [255:0]     exp_vec;
    } vec_t;

    typedef struct {
        logic         wen;
        logic [4:0]   waddr;
        logic [255:0] wvec;
        int           at_edge;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference merge: old contents with masked body elements replaced.
    function automatic logic [255:0] model(input vec_t v);
        logic [255:0] r;
        int vlc;
        r   = v.old;
        vlc = (v.vl > 4'd8) ? 8 : int'(v.vl);
        for (int i = 0; i < vlc; i++)
            if (v.mask[i]) r[32*i +: 32] = v.beats[i];
        return r;
    endfunction

    // Output monitor: every done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 256'(done), 256'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("wen_p", 256'(wen_p), 256'(mon_e.wen));
                    chk("waddr_p", 256'(waddr_p), 256'(mon_e.waddr));
                    chk("wvec_p", wvec_p, mon_e.wvec);
                    chk("done_cycle", 256'(cyc), 256'(mon_e.at_edge));
                end
            end else if (wen_p) begin
                chk("wen_without_done", 256'(wen_p), 256'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) step();
        chk("idle_timeout", 256'(busy), 256'(0));
    endtask

    task automatic run_op(input vec_t v);
        int   t;
        int   vlc;
        exp_t e;
        for (int i = 0; i < 60 && !start_rdy; i++) step();
        chk("start_rdy", 256'(start_rdy), 256'(1));
        start_val   = 1'b1;
        start_waddr = v.waddr;
        start_vl    = v.vl;
        start_mask  = v.mask;
        start_old   = v.old;
        step();
        start_val = 1'b0;
        t   = cyc;
        vlc = (v.vl > 4'd8) ? 8 : int'(v.vl);
        if (v.kill_after < 0) begin
            e.wen     = v.exp_wen;
            e.waddr   = v.waddr;
            e.wvec    = v.exp_vec;
            e.at_edge = t + vlc + ((vlc > 0) ? v.gap * (vlc - 1) : 0);
            sb.push_back(e);
        end
        if (vlc == 0) chk("vl0_elem_rdy", 256'(elem_rdy), 256'(0));
        for (int k = 0; k < vlc; k++) begin
            if (k == v.kill_after) begin
                kill      = 1'b1;
                elem_val  = 1'b1;
                elem_data = 32'hDEAD_BEEF;
                #1;
                chk("kill_elem_rdy", 256'(elem_rdy), 256'(0));
                step();
                kill     = 1'b0;
                elem_val = 1'b0;
                chk("kill_busy", 256'(busy), 256'(0));
                break;
            end
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    elem_val = 1'b0;
                    #1;
                    chk("stall_busy", 256'(busy), 256'(1));
                    step();
                end
            end
            elem_val  = 1'b1;
            elem_data = v.beats[k];
            #1;
            chk("beat_elem_rdy", 256'(elem_rdy), 256'(1));
            step();
        end
        elem_val = 1'b0;
        if (v.extra_beat) begin
            elem_val  = 1'b1;
            elem_data = 32'h0BAD_0BAD;
            #1;
            chk("extra_beat_rdy", 256'(elem_rdy), 256'(0));
            step();
            elem_val = 1'b0;
        end
        wait_idle();
    endtask

    function automatic vec_t blank();
        vec_t v;
        v.waddr = '0; v.vl = '0; v.mask = '0; v.old = '0; v.beats = '0;
        v.gap = 0; v.kill_after = -1; v.extra_beat = 1'b0;
        v.exp_wen = 1'b0; v.exp_vec = '0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full vector: all eight lanes overwritten.
        tbl[0] = blank();
        tbl[0].waddr = 5'd3; tbl[0].vl = 4'd8; tbl[0].mask = 8'hFF; tbl[0].old = '1;
        for (int i = 0; i < 8; i++) begin
            tbl[0].beats[i] = 32'h10 + 32'(i);
            tbl[0].exp_vec[32*i +: 32] = 32'h10 + 32'(i);
        end
        tbl[0].exp_wen = 1'b1;
        // Masked body plus undisturbed tail.
        tbl[1] = blank();
        tbl[1].waddr = 5'd7; tbl[1].vl = 4'd5; tbl[1].mask = 8'b0001_0101;
        for (int i = 0; i < 8; i++) tbl[1].old[32*i +: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 5; i++) tbl[1].beats[i] = 32'(i + 1);
        tbl[1].exp_vec = {32'hA7, 32'hA6, 32'hA5, 32'h5, 32'hA3, 32'h3, 32'hA1, 32'h1};
        tbl[1].exp_wen = 1'b1;
        // vl == 0: immediate completion, no write.
        tbl[2] = blank();
        tbl[2].waddr = 5'd9; tbl[2].vl = 4'd0; tbl[2].mask = 8'hFF; tbl[2].old = {8{32'h5555_AAAA}};
        tbl[2].exp_vec = {8{32'h5555_AAAA}};
        // vl == 12 clamps to 8; a ninth beat must be refused.
        tbl[3] = blank();
        tbl[3].waddr = 5'd31; tbl[3].vl = 4'd12; tbl[3].mask = 8'hFF; tbl[3].extra_beat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tbl[3].beats[i] = 32'hC000_0000 + 32'(i);
            tbl[3].exp_vec[32*i +: 32] = 32'hC000_0000 + 32'(i);
        end
        tbl[3].exp_wen = 1'b1;
        // Destination x0 with bubbles between beats.
        tbl[4] = blank();
        tbl[4].waddr = 5'd0; tbl[4].vl = 4'd2; tbl[4].mask = 8'hFF; tbl[4].gap = 3;
        tbl[4].beats[0] = 32'h1111; tbl[4].beats[1] = 32'h2222;
        tbl[4].exp_vec[63:0] = {32'h2222, 32'h1111};
        // Kill after two of four beats, then a normal op.
        tbl[5] = blank();
        tbl[5].waddr = 5'd4; tbl[5].vl = 4'd4; tbl[5].mask = 8'hFF; tbl[5].kill_after = 2;
        tbl[5].beats[0] = 32'h7; tbl[5].beats[1] = 32'h8;
        tbl[6] = blank();
        tbl[6].waddr = 5'd5; tbl[6].vl = 4'd3; tbl[6].mask = 8'b0000_0110; tbl[6].old = {8{32'hFFFF_0000}};
        tbl[6].beats[0] = 32'h1; tbl[6].beats[1] = 32'h2; tbl[6].beats[2] = 32'h3;
        tbl[6].exp_vec = {{5{32'hFFFF_0000}}, 32'h3, 32'h2, 32'hFFFF_0000};
        tbl[6].exp_wen = 1'b1;
        // Random ops checked against the reference merge.
        for (int r = 7; r < 9; r++) begin
            tbl[r] = blank();
            tbl[r].waddr = 5'($urandom_range(1, 31));
            tbl[r].vl    = 4'($urandom_range(1, 15));
            tbl[r].mask  = 8'($urandom);
            tbl[r].gap   = $urandom_range(0, 2);
            for (int i = 0; i < 8; i++) begin
                tbl[r].old[32*i +: 32] = $urandom;
                tbl[r].beats[i] = $urandom;
            end
            tbl[r].exp_wen = 1'b1;
            tbl[r].exp_vec = model(tbl[r]);
        end

        reset = 1'b1; start_val = 1'b0; start_waddr = '0; start_vl = '0; start_mask = '0;
        start_old = '0; elem_val = 1'b0; elem_data = '0; kill = 1'b0;
        #1;
        chk("rst_start_rdy", 256'(start_rdy), 256'(1));
        chk("rst_elem_rdy", 256'(elem_rdy), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_wen_p", 256'(wen_p), 256'(0));
        chk("rst_waddr_p", 256'(waddr_p), 256'(0));
        chk("rst_wvec_p", wvec_p, 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        step();

        for (int n = 0; n < 9; n++) run_op(tbl[n]);

        // Asynchronous reset mid-COLLECT: op discarded, nothing written afterwards.
        start_val = 1'b1; start_waddr = 5'd12; start_vl = 4'd4; start_mask = 8'hFF; start_old = '0;
        step();
        start_val = 1'b0;
        for (int k = 0; k < 2; k++) begin
            elem_val = 1'b1; elem_data = 32'h9999_0000 + 32'(k);
            step();
        end
        elem_val = 1'b0;
        chk("pre_reset_busy", 256'(busy), 256'(1));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_busy", 256'(busy), 256'(0));
        chk("async_wen_p", 256'(wen_p), 256'(0));
        chk("async_start_rdy", 256'(start_rdy), 256'(1));
        chk("async_elem_rdy", 256'(elem_rdy), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_start_rdy", 256'(start_rdy), 256'(1));
        repeat (6) step();
        run_op(tbl[6]);

        repeat (3) step();
        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
